// File: rtl/music_pkg.sv
// Shared types for the song sequencer: transport state, beat index, rest threshold.
// Pure declarations; no logic, no latency, no backpressure.
package music_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [7:0] beat_t;

    localparam int unsigned SILENCE_HZ_DEF = 20000;

endpackage

// File: rtl/music_sequencer_if.sv
// Transport controls, song-table lookup and speaker outputs of the sequencer.
// master = sequencer side, slave = board/song-table side; no handshake, all level/pulse.
interface music_sequencer_if;

    logic               play_toggle;
    logic               stop;
    logic               loop_en;
    logic [31:0]        tone;
    music_pkg::beat_t   beat_num;
    logic               pwm;
    logic               playing;
    logic               done;

    modport master (
        input  play_toggle, stop, loop_en, tone,
        output beat_num, pwm, playing, done
    );

    modport slave (
        output play_toggle, stop, loop_en, tone,
        input  beat_num, pwm, playing, done
    );

endinterface

// File: rtl/tone_pwm.sv
// Phase-accumulator square wave: average toggle rate gives exactly tone Hz; 1-cycle register latency.
// No backpressure; output is gated low immediately while disabled or resting.
module tone_pwm #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned SILENCE_HZ = music_pkg::SILENCE_HZ_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] tone,
    output logic        pwm
);

    localparam logic [31:0] HALF = 32'(CLK_HZ / 2);
    localparam logic [31:0] SIL  = 32'(SILENCE_HZ);

    logic [31:0] acc;
    logic [31:0] sum;
    logic        pwm_q;
    logic        audible;

    // acc < HALF and tone < SILENCE_HZ <= HALF, so sum stays below CLK_HZ
    assign audible = en && (tone < SIL);
    assign sum     = acc + tone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            pwm_q <= 1'b0;
        end else if (!audible) begin
            acc   <= '0;
            pwm_q <= 1'b0;
        end else if (sum >= HALF) begin
            acc   <= sum - HALF;
            pwm_q <= ~pwm_q;
        end else begin
            acc   <= sum;
        end
    end

    assign pwm = pwm_q & audible;

endmodule

// File: rtl/music_sequencer.sv
// Song player: tempo counter, beat index and play/pause/stop FSM feeding tone_pwm.
// beat_num/playing/done registered (1 cycle after the causing event); no backpressure.
module music_sequencer
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BEAT_HZ    = 8,
    parameter int unsigned LAST_BEAT  = 255,
    parameter int unsigned SILENCE_HZ = SILENCE_HZ_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    music_sequencer_if.master bus
);

    localparam int unsigned TICK_MAX  = CLK_HZ / BEAT_HZ - 1;
    localparam int          CW        = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_MAX);
    localparam beat_t       LAST      = beat_t'(LAST_BEAT);

    state_t        state;
    logic [CW-1:0] tick_cnt;
    beat_t         beat_q;
    logic          playing_q;
    logic          done_q;
    logic          tick;
    logic          at_end;

    assign tick   = (state == PLAY) && (tick_cnt == TICK_LAST);
    assign at_end = (beat_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            beat_q    <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state     <= IDLE;
                tick_cnt  <= '0;
                beat_q    <= '0;
                playing_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        beat_q   <= '0;
                        if (bus.play_toggle) begin
                            state     <= PLAY;
                            playing_q <= 1'b1;
                        end
                    end
                    PLAY: begin
                        tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
                        // final-beat tick wins over a coincident toggle
                        if (tick && at_end) begin
                            beat_q <= '0;
                            if (!bus.loop_en) begin
                                state     <= IDLE;
                                playing_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            if (tick) begin
                                beat_q <= beat_q + 8'd1;
                            end
                            if (bus.play_toggle) begin
                                state     <= PAUSE;
                                playing_q <= 1'b0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (bus.play_toggle) begin
                            state     <= PLAY;
                            playing_q <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        tick_cnt  <= '0;
                        beat_q    <= '0;
                        playing_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    tone_pwm #(
        .CLK_HZ     (CLK_HZ),
        .SILENCE_HZ (SILENCE_HZ)
    ) u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (playing_q),
        .tone  (bus.tone),
        .pwm   (bus.pwm)
    );

    assign bus.beat_num = beat_q;
    assign bus.playing  = playing_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: directed vector table, hand sequences and random transport
// stimulus, all checked against a cycle-level behavioural model of the song player.
module tb_music_sequencer;

    localparam int CLK_HZ    = 1000;
    localparam int BEAT_HZ   = 100;
    localparam int LAST_BEAT = 3;
    localparam int SIL       = 400;
    localparam int TICK_MAX  = CLK_HZ / BEAT_HZ - 1;
    localparam int HALF      = CLK_HZ / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    music_sequencer_if bus();
    logic [31:0] song [256];
    assign bus.tone = song[bus.beat_num];

    music_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .BEAT_HZ    (BEAT_HZ),
        .LAST_BEAT  (LAST_BEAT),
        .SILENCE_HZ (SIL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    // reference model: transport mode, position in beat, beat, tone phase
    typedef enum int { M_IDLE, M_PLAY, M_PAUSE } mode_t;
    mode_t m_mode;
    int    m_cnt, m_beat, m_acc;
    bit    m_pwm, m_done;

    function automatic void model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_beat = 0; m_acc = 0; m_pwm = 0; m_done = 0;
    endfunction

    function automatic void model_step(bit pt, bit st, bit le);
        int t;
        bit tick;
        t    = int'(song[m_beat]);
        tick = (m_mode == M_PLAY) && (m_cnt == TICK_MAX);
        if (m_mode == M_PLAY && t < SIL) begin
            m_acc = m_acc + t;
            if (m_acc >= HALF) begin
                m_acc = m_acc - HALF;
                m_pwm = !m_pwm;
            end
        end else begin
            m_acc = 0;
            m_pwm = 0;
        end
        m_done = 0;
        if (st) begin
            m_mode = M_IDLE; m_cnt = 0; m_beat = 0;
        end else if (m_mode == M_IDLE) begin
            if (pt) m_mode = M_PLAY;
        end else if (m_mode == M_PAUSE) begin
            if (pt) m_mode = M_PLAY;
        end else if (tick && m_beat == LAST_BEAT) begin
            m_cnt = 0; m_beat = 0;
            if (!le) begin
                m_mode = M_IDLE;
                m_done = 1;
            end
        end else begin
            if (tick) begin
                m_cnt  = 0;
                m_beat = m_beat + 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (pt) m_mode = M_PAUSE;
        end
    endfunction

    function automatic int model_pwm();
        return (m_mode == M_PLAY && int'(song[m_beat]) < SIL) ? int'(m_pwm) : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("model_beat",    int'(bus.beat_num), m_beat);
        chk("model_playing", int'(bus.playing),  int'(m_mode == M_PLAY));
        chk("model_done",    int'(bus.done),     int'(m_done));
        chk("model_pwm",     int'(bus.pwm),      model_pwm());
    endtask

    // called just after a falling edge; returns just after the next falling edge
    task automatic cyc(input bit pt, input bit st);
        bus.play_toggle = pt;
        bus.stop        = st;
        @(posedge clk);
        model_step(pt, st, bus.loop_en);
        @(negedge clk);
        bus.play_toggle = 1'b0;
        bus.stop        = 1'b0;
        chk_model();
    endtask

    typedef struct {
        bit pt;
        bit st;
        bit le;
        int n;      // cycles to run, inputs applied on the first only
        int beat;
        bit ply;
        bit dn;
        int pw;     // -1: not checked directly
    } vec_t;

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < 256; i++) song[i] = 32'd0;
        song[0] = 32'd100;
        song[1] = 32'd125;
        song[2] = 32'd60;
        song[3] = 32'd400;
        bus.play_toggle = 1'b0;
        bus.stop        = 1'b0;
        bus.loop_en     = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_beat",    int'(bus.beat_num), 0);
        chk("rst_playing", int'(bus.playing),  0);
        chk("rst_done",    int'(bus.done),     0);
        chk("rst_pwm",     int'(bus.pwm),      0);
        rst_n = 1'b1;

        // no loop: 1,2,3 then end with single done pulse
        tbl.push_back('{1,0,0, 1, 0,1,0,  0});
        tbl.push_back('{0,0,0,10, 1,1,0, -1});
        tbl.push_back('{0,0,0,10, 2,1,0, -1});
        tbl.push_back('{0,0,0,10, 3,1,0, -1});
        tbl.push_back('{0,0,0, 9, 3,1,0,  0});
        tbl.push_back('{0,0,0, 1, 0,0,1,  0});
        tbl.push_back('{0,0,0, 1, 0,0,0,  0});
        // looping wraps 3 -> 0 while still playing
        tbl.push_back('{1,0,1, 1, 0,1,0,  0});
        tbl.push_back('{0,0,1,30, 3,1,0,  0});
        tbl.push_back('{0,0,1,10, 0,1,0, -1});
        tbl.push_back('{0,0,1,10, 1,1,0, -1});
        tbl.push_back('{0,1,1, 1, 0,0,0,  0});
        // pause at count 4 of beat 1, resume, next step 6 cycles after toggle
        tbl.push_back('{1,0,0, 1, 0,1,0,  0});
        tbl.push_back('{0,0,0,14, 1,1,0, -1});
        tbl.push_back('{1,0,0, 1, 1,0,0,  0});
        tbl.push_back('{0,0,0, 5, 1,0,0,  0});
        tbl.push_back('{1,0,0, 5, 1,1,0, -1});
        tbl.push_back('{0,0,0, 1, 2,1,0, -1});
        // stop beats toggle
        tbl.push_back('{1,1,0, 1, 0,0,0,  0});
        tbl.push_back('{0,0,0, 2, 0,0,0,  0});
        // stop on the final-beat tick: no done
        tbl.push_back('{1,0,0, 1, 0,1,0,  0});
        tbl.push_back('{0,0,0,39, 3,1,0,  0});
        tbl.push_back('{0,1,0, 1, 0,0,0,  0});
        tbl.push_back('{0,0,0, 1, 0,0,0,  0});

        foreach (tbl[r]) begin
            bus.loop_en = tbl[r].le;
            cyc(tbl[r].pt, tbl[r].st);
            for (int k = 1; k < tbl[r].n; k++) cyc(1'b0, 1'b0);
            chk($sformatf("row%0d_beat", r),    int'(bus.beat_num), tbl[r].beat);
            chk($sformatf("row%0d_playing", r), int'(bus.playing),  int'(tbl[r].ply));
            chk($sformatf("row%0d_done", r),    int'(bus.done),     int'(tbl[r].dn));
            if (tbl[r].pw >= 0)
                chk($sformatf("row%0d_pwm", r), int'(bus.pwm), tbl[r].pw);
        end
        bus.loop_en = 1'b0;

        // tone 100 Hz: high from the 6th to the 10th play cycle
        cyc(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) cyc(1'b0, 1'b0);
            chk($sformatf("tone100_c%0d", k), int'(bus.pwm), (k >= 6) ? 1 : 0);
        end
        cyc(1'b0, 1'b1);

        // tone at the silence threshold is a rest
        song[0] = 32'd400;
        cyc(1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) cyc(1'b0, 1'b0);
            chk($sformatf("rest_c%0d", k), int'(bus.pwm), 0);
        end
        cyc(1'b0, 1'b1);
        song[0] = 32'd100;

        // asynchronous reset mid-song at beat 2
        cyc(1'b1, 1'b0);
        repeat (20) cyc(1'b0, 1'b0);
        chk("pre_rst_beat", int'(bus.beat_num), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_beat",    int'(bus.beat_num), 0);
        chk("async_rst_pwm",     int'(bus.pwm),      0);
        chk("async_rst_playing", int'(bus.playing),  0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_model();

        // random transport and song contents
        for (int i = 0; i < 4; i++) song[i] = 32'($urandom_range(450));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) bus.loop_en = ~bus.loop_en;
            if (i % 600 == 599 && m_mode == M_IDLE)
                for (int j = 0; j < 4; j++) song[j] = 32'($urandom_range(450));
            cyc($urandom_range(15) == 0, $urandom_range(63) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
# music_sequencer

Plays the 256-entry song table by driving the table's 8-bit beat index at a fixed tempo. It converts the tone frequency the table returns into a square wave for the speaker output. Transport control is play/pause toggle, stop and loop-enable. The block sits between the board's button/switch debouncers and the song lookup table.

## Interface
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BEAT_HZ, 8: beat-index advance rate in quarter-beats per second.
- LAST_BEAT, 255: final beat index of the song.
- SILENCE_HZ, 20000: any tone at or above this value is a rest. It must be ≤ CLK_HZ/2.
- clk, input, 1: system clock. There is one clock domain.
- rst_n, input, 1: reset, asynchronous and active-low.
- play_toggle, input, 1: one-cycle pulse that starts or pauses playback.
- stop, input, 1: one-cycle pulse that aborts playback and rewinds to beat 0.
- loop_en, input, 1: level input. When 1, playback wraps at LAST_BEAT instead of ending.
- tone, input, 32: frequency in Hz for the current beat_num, returned combinationally by the song table.
- beat_num, output, 8: registered beat index driven to the song table.
- pwm, output, 1: square-wave speaker drive.
- playing, output, 1: 1 while the state is PLAY.
- done, output, 1: one-cycle pulse when the song ends without looping.

## Operation
- States: IDLE, PLAY, PAUSE.
- IDLE + play_toggle → PLAY.
- PLAY + play_toggle → PAUSE.
- PAUSE + play_toggle → PLAY.
- stop → IDLE from any state.
- Tempo counter:
  - TICK_MAX = CLK_HZ/BEAT_HZ − 1.
  - Counts only in PLAY. When the count equals TICK_MAX, a beat tick is generated and the counter returns to 0.
  - Holds its value in PAUSE. Cleared in IDLE.
- On a beat tick with beat_num < LAST_BEAT: beat_num increments by 1.
- On a beat tick with beat_num == LAST_BEAT:
  - If loop_en = 1: beat_num becomes 0 and the state stays PLAY.
  - Otherwise: state becomes IDLE, beat_num becomes 0, and done pulses for 1 cycle.
- beat_num holds its value in PAUSE. It is forced to 0 in IDLE.
- Tone generator (phase accumulator):
  - HALF = CLK_HZ/2.
  - Each PLAY cycle with tone < SILENCE_HZ: sum = acc + tone.
  - If sum ≥ HALF: acc ← sum − HALF and pwm toggles. Otherwise acc ← sum.
  - Because tone < HALF, pwm toggles at most once per cycle. The average output frequency is exactly tone Hz.
  - Accumulator width is 32 bits unsigned and must not overflow.
- Rest handling: when tone ≥ SILENCE_HZ, or the state is not PLAY, pwm is forced to 0 and acc to 0.
- Simultaneous events:
  - stop beats play_toggle.
  - stop beats a beat tick in the same cycle; done is not asserted.
  - A play_toggle arriving in the same cycle as the end-of-song tick is ignored; the end-of-song behaviour wins.

## Timing
- Reset values: state IDLE, beat_num 0, pwm 0, playing 0, done 0, tempo counter 0, acc 0.
- A play_toggle in cycle n gives playing = 1 in cycle n+1.
- From PLAY entry (first PLAY cycle), the first beat_num increment occurs TICK_MAX+1 cycles later.
- A beat_num change in cycle n has its tone accumulated from cycle n onward. The table is combinational, so there is no extra latency.
- done is asserted in the same cycle that playing falls.
- rst_n assertion mid-song returns all registers to reset values immediately, with no clock edge required.
- Deassertion of rst_n is synchronised to clk by the top level, not by this block.

## Structure
- Shared package music_pkg holds:
  - the state enum (IDLE/PLAY/PAUSE);
  - the SILENCE_HZ default of 20000;
  - the 8-bit beat-index type.
- The phase-accumulator square-wave generator is a sub-module, tone_pwm.
  - Inputs: clk, rst_n, en, tone.
  - Output: pwm.
  - Parameters: CLK_HZ, SILENCE_HZ.
- Tempo counter, beat counter and FSM stay in music_sequencer.

## Test plan
All scenarios use CLK_HZ=1000, BEAT_HZ=100 (TICK_MAX=9, HALF=500), SILENCE_HZ=400, LAST_BEAT=3.
- Reset mid-play at beat 2: assert rst_n = 0 → beat_num=0, pwm=0, playing=0 in the same cycle.
- Tone generator: tone=100, pulse play_toggle → pwm toggles every 5 cycles (period 10 cycles).
  - With tone=400 (rest) → pwm stays 0.
- Beat sequencing, loop_en=0, pulse play → beat_num steps 1, 2, 3 at 10-cycle intervals.
  - On the next tick: beat_num=0, playing=0, done high for exactly 1 cycle.
- Looping, loop_en=1 → beat_num sequence is 3 then 0 with playing held 1 and done never asserted.
- Pause at tempo count 4 on beat 1 → beat_num holds, pwm=0. Resume → the next increment occurs 6 cycles later.
- Collisions:
  - stop and play_toggle in the same cycle → IDLE, beat_num=0.
  - stop coincident with the final-beat tick → done stays 0.
